secret_sm_encoder: RTL
======================

Name: secret_sm_encoder

Overview:
- Feeds the schoolbook multiplier's small ALUs with secret coefficients in the 4-bit sign-magnitude form they consume: bit 3 is the sign (1 means subtract), bits 2:0 are the magnitude 0..4.
- Accepts packed 64-bit words, each holding 16 two's-complement 4-bit secret coefficients, from the secret buffer.
- Streams one encoded coefficient per cycle with a polynomial index and a last flag.
- Flags any coefficient the ALU cannot represent.

Parameters:
- COEFFS_PER_WORD, 16, number of 4-bit coefficients per input word.
- N, 256, coefficients per polynomial; out_idx wraps at N.
- MAX_MAG, 4, largest legal magnitude. The ALU maps any s[2:0] >= 4 to ax4, so larger values must never pass through.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous: flushes the buffered word, zeroes out_idx, clears err.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  encoder can accept in_word this cycle.
- in_word  input  64  packed coefficients; coefficient k is in bits [4k+3:4k], k=0 is sent first.
- out_valid  output  1  out_s is valid.
- out_ready  input  1  downstream accepts out_s.
- out_s  output  4  sign-magnitude coefficient {sign, mag[2:0]}.
- out_idx  output  8  coefficient index within the polynomial, 0..N-1.
- out_last  output  1  high with the coefficient at out_idx == N-1.
- err  output  1  sticky illegal-coefficient flag.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_s=0, out_idx=0, out_last=0, err=0.
  - Nibble counter = 0, holding register empty.
  - in_ready=1 one cycle after rst_n deasserts.
  - A word in progress is discarded, with no partial output afterwards.
- Storage:
  - One 64-bit holding register plus a 4-bit nibble counter c.
  - The register is full while nibbles remain to be sent.
- Handshakes:
  - A transfer occurs on a rising edge with valid && ready on the respective side.
  - in_ready = !full || (out_valid && out_ready && c == COEFFS_PER_WORD-1), and is forced 0 while clear=1.
  - This lets a new word load on the same edge the last nibble leaves, so there is no bubble.
- Latency and throughput:
  - Word accepted at edge t means nibble 0 is presented with out_valid=1 after edge t.
  - Throughput is 1 coefficient per cycle while out_ready=1.
- Backpressure:
  - When out_valid=1 and out_ready=0, out_s, out_idx and out_last hold stable.
  - out_valid stays high until the handshake.
- Encoding of nibble v = word[4c+3:4c] (registered outputs):
  - v = 0 gives 4'b0000; negative zero is never produced.
  - v in 1..MAX_MAG gives {0, v[2:0]}.
  - v in -MAX_MAG..-1 (4'hC..4'hF) gives {1, (-v)[2:0]}.
  - Anything else (5..7, -8..-5) gives out_s = 4'b0000 and err becomes 1 when that coefficient is presented. The coefficient is still emitted and the index still advances.
- out_idx and out_last:
  - out_idx increments on each output handshake and wraps from N-1 to 0.
  - out_last = (out_idx == N-1), combinational from the registered idx.
- Word completion: after the handshake of nibble 15, the register empties unless a new word loads on the same edge.
- err:
  - Sticky; cleared only by rst_n or clear.
  - If clear and an illegal nibble are presented in the same cycle, clear wins.
- clear, in one cycle:
  - out_valid goes 0 next cycle and the buffered word is dropped.
  - out_idx=0, err=0, c=0.
  - No input is accepted during clear.
- Simultaneous out handshake and in handshake on the last nibble: the new word's nibble 0 appears on the following cycle and out_idx continues counting.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → all outputs 0 and in_ready=0 during reset. After release, in_ready=1 next cycle and out_valid=0.
- Legal encode: in_word=64'h0000_0000_CDEF_4321, out_ready=1 → out_s = 1,2,3,4,9,A,B,C, then 8×0, on consecutive cycles. out_idx runs 0..15, err=0.
- Illegal values: nibbles 0x5, 0x8, 0xB → out_s=0 for each, err=1 from the first one presented and it stays 1. A clear pulse then sets err=0 and out_idx=0.
- Backpressure: drop out_ready for 3 cycles at out_idx=6 → out_s and out_idx stay constant. The stream resumes with idx 7 and no loss or duplication.
- Streaming: 16 words back-to-back with in_valid=1 and out_ready=1 → 256 outputs in 256 consecutive cycles with no bubbles. in_ready pulses on each last nibble, out_last=1 only at idx 255, the next word restarts at idx 0.
- Reset mid-word: assert rst_n=0 at nibble 9 → outputs clear immediately. After release, a new word starts at idx 0, nibble 0.

Source files
------------

// File: rtl/secret_sm_encoder.sv
// Unpacks 64-bit words of two's-complement 4-bit secret coefficients and streams them
// one per cycle in the ALU's sign-magnitude form, with index, last flag and sticky error.
module secret_sm_encoder #(
  parameter int unsigned COEFFS_PER_WORD = 16,
  parameter int unsigned N               = 256,
  parameter int unsigned MAX_MAG         = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4*COEFFS_PER_WORD-1:0]   in_word,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [3:0]                     out_s,
  output logic [7:0]                     out_idx,
  output logic                           out_last,
  output logic                           err
);

  localparam int unsigned CW       = $clog2(COEFFS_PER_WORD);
  localparam logic [CW-1:0] C_LAST = CW'(COEFFS_PER_WORD - 1);
  localparam logic [7:0] IDX_LAST  = 8'(N - 1);
  localparam logic [3:0] MAG_MAX   = 4'(MAX_MAG);

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_t;

  state_t                         state_q, state_d;
  logic                           rdy_en_q;
  logic [4*COEFFS_PER_WORD-1:0]   word_q;
  logic [CW-1:0]                  c_q;
  logic [CW-1:0]                  c_inc;
  logic [7:0]                     idx_q;
  logic [3:0]                     s_q;
  logic                           err_q;

  logic                           out_fire;
  logic                           last_nib;
  logic                           in_ready_c;
  logic                           load;
  logic                           advance;
  logic [3:0]                     nib;
  logic [3:0]                     neg;
  logic [3:0]                     enc_s;
  logic                           enc_bad;

  // Next-state, handshake and encoding of the nibble that will be presented next.
  always_comb begin
    state_d    = state_q;
    out_fire   = (state_q == ST_FULL) && out_ready;
    last_nib   = (c_q == C_LAST);
    c_inc      = c_q + CW'(1);
    in_ready_c = rdy_en_q && !clear && ((state_q == ST_EMPTY) || (out_fire && last_nib));
    load       = in_valid && in_ready_c;
    advance    = out_fire && !last_nib;
    nib        = load ? in_word[3:0] : word_q[{c_inc, 2'b00} +: 4];
    neg        = 4'd0 - nib;
    enc_s      = '0;
    enc_bad    = 1'b0;

    if (nib == 4'd0) begin
      enc_s = '0;
    end else if (!nib[3] && (nib <= MAG_MAX)) begin
      enc_s = {1'b0, nib[2:0]};
    end else if (nib[3] && (neg <= MAG_MAX)) begin
      enc_s = {1'b1, neg[2:0]};
    end else begin
      enc_bad = 1'b1;
    end

    if (clear) begin
      state_d = ST_EMPTY;
    end else if (load) begin
      state_d = ST_FULL;
    end else if (out_fire && last_nib) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rdy_en_q <= 1'b0;
      word_q   <= '0;
      c_q      <= '0;
      idx_q    <= '0;
      s_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      state_q  <= state_d;
      if (clear) begin
        c_q   <= '0;
        idx_q <= '0;
        s_q   <= '0;
        err_q <= 1'b0;
      end else begin
        if (out_fire) begin
          idx_q <= (idx_q == IDX_LAST) ? 8'd0 : idx_q + 8'd1;
        end
        // err is raised on the same edge the illegal coefficient becomes visible.
        if (load) begin
          word_q <= in_word;
          c_q    <= '0;
          s_q    <= enc_s;
          err_q  <= err_q | enc_bad;
        end else if (advance) begin
          c_q    <= c_inc;
          s_q    <= enc_s;
          err_q  <= err_q | enc_bad;
        end else if (out_fire) begin
          c_q    <= '0;
          s_q    <= '0;
        end
      end
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = (state_q == ST_FULL);
  assign out_s     = s_q;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == IDX_LAST);
  assign err       = err_q;

endmodule
